// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and constants for the JPEG frame-level control path.
package jpeg_ctrl_pkg;

    // Frame sequencer states. ST_RSTM is reachable only when restart markers are built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_RSTM  = 3'd5,
        ST_EOI   = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Component order inside one 4:4:4 MCU.
    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    // JPEG marker codes emitted by the header, restart and EOI writers.
    localparam logic [15:0] SOI  = 16'hFFD8;
    localparam logic [15:0] EOI  = 16'hFFD9;
    localparam logic [15:0] RST0 = 16'hFFD0;

endpackage

// File: rtl/jpeg_mcu_counter.sv
// Nested block position counter: component fastest, then MCU column, then MCU row.
// 'last' flags the final block of the frame and 'mcu_wrap' flags the last component of an MCU.
module jpeg_mcu_counter
    import jpeg_ctrl_pkg::*;
#(
    parameter int MCU_X  = 80,
    parameter int MCU_Y  = 60,
    parameter int N_COMP = 3,
    parameter int X_W    = $clog2(MCU_X),
    parameter int Y_W    = $clog2(MCU_Y)
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    input  logic           inc,
    input  logic           clr,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     comp,
    output logic           last,
    output logic           mcu_wrap
);

    localparam logic [X_W-1:0] X_MAX = X_W'(MCU_X - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(MCU_Y - 1);
    localparam logic [1:0]     C_MAX = 2'(N_COMP - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [1:0]     comp_q, comp_d;
    logic           comp_end, x_end, y_end;

    assign comp_end = (comp_q == C_MAX);
    assign x_end    = (x_q == X_MAX);
    assign y_end    = (y_q == Y_MAX);

    // Next position: clear wins over increment; carries ripple comp -> x -> y.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        comp_d = comp_q;
        if (clr) begin
            x_d    = '0;
            y_d    = '0;
            comp_d = COMP_Y;
        end else if (inc) begin
            if (comp_end) begin
                comp_d = COMP_Y;
                if (x_end) begin
                    x_d = '0;
                    y_d = y_end ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end else begin
                comp_d = comp_q + 2'd1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            comp_q <= COMP_Y;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            comp_q <= comp_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign comp     = comp_q;
    assign last     = comp_end && x_end && y_end;
    assign mcu_wrap = comp_end;

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame-level sequencer for the JPEG encoder: header, per-block requests to the block
// encoder over valid/ready + done, then EOI. Optional restart markers between MCU
// groups are built in when JPEG_RESTART_MARKER_EN is defined (adds input rst_mrk_done).
module jpeg_frame_ctrl
    import jpeg_ctrl_pkg::*;
#(
    parameter int IMG_W        = 640,
    parameter int IMG_H        = 480,
    parameter int N_COMP       = 3,
    parameter int RST_INTERVAL = 4
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       hdr_start,
    input  logic                       hdr_done,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic [$clog2(IMG_W/8)-1:0] blk_x,
    output logic [$clog2(IMG_H/8)-1:0] blk_y,
    output logic [1:0]                 blk_comp,
    output logic                       blk_last,
    input  logic                       blk_done,
    output logic                       dc_clr,
    output logic                       eoi_start,
    input  logic                       eoi_done,
    output logic                       rst_mrk_start,
    output logic [2:0]                 rst_mrk_idx
`ifdef JPEG_RESTART_MARKER_EN
    ,
    input  logic                       rst_mrk_done
`endif
);

    localparam int MCU_X = IMG_W / 8;
    localparam int MCU_Y = IMG_H / 8;
    localparam int X_W   = $clog2(MCU_X);
    localparam int Y_W   = $clog2(MCU_Y);

    // Reject geometries the counter widths cannot represent.
    if ((IMG_W % 8) != 0 || MCU_X < 2) begin : g_bad_img_w
        $error("IMG_W must be a multiple of 8 and at least 16");
    end
    if ((IMG_H % 8) != 0 || MCU_Y < 2) begin : g_bad_img_h
        $error("IMG_H must be a multiple of 8 and at least 16");
    end
    if (N_COMP < 1 || N_COMP > 4) begin : g_bad_ncomp
        $error("N_COMP must be 1..4");
    end
    if (RST_INTERVAL < 1 || RST_INTERVAL > 65535) begin : g_bad_interval
        $error("RST_INTERVAL must be 1..65535");
    end

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   frame_done_q, frame_done_d;
    logic   hdr_start_q, hdr_start_d;
    logic   dc_clr_q, dc_clr_d;
    logic   eoi_start_q, eoi_start_d;
    logic   blk_valid_q, blk_valid_d;

    logic   cnt_inc, cnt_clr, cnt_last, cnt_mcu_wrap;

`ifdef JPEG_RESTART_MARKER_EN
    logic        rst_mrk_start_q, rst_mrk_start_d;
    logic [2:0]  rst_idx_q, rst_idx_d;
    // Counts MCUs since the last marker; wrapping at RST_INTERVAL makes "multiple of
    // the interval" a plain equality compare.
    logic [15:0] mcu_cnt_q, mcu_cnt_d;
    logic [15:0] mcu_cnt_inc;
    assign mcu_cnt_inc = mcu_cnt_q + 16'd1;
`else
    // The MCU-boundary flag only feeds restart-marker pacing.
    logic mcu_wrap_unused;
    assign mcu_wrap_unused = cnt_mcu_wrap;
`endif

    jpeg_mcu_counter #(
        .MCU_X  (MCU_X),
        .MCU_Y  (MCU_Y),
        .N_COMP (N_COMP),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_mcu_counter (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .x        (blk_x),
        .y        (blk_y),
        .comp     (blk_comp),
        .last     (cnt_last),
        .mcu_wrap (cnt_mcu_wrap)
    );

    // Next-state and next-output logic; every pulse output is raised on the transition
    // into its state so it appears in the first cycle of that state.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        hdr_start_d  = 1'b0;
        dc_clr_d     = 1'b0;
        eoi_start_d  = 1'b0;
        blk_valid_d  = blk_valid_q;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;
`ifdef JPEG_RESTART_MARKER_EN
        rst_mrk_start_d = 1'b0;
        rst_idx_d       = rst_idx_q;
        mcu_cnt_d       = mcu_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_HDR;
                    busy_d      = 1'b1;
                    hdr_start_d = 1'b1;
                    dc_clr_d    = 1'b1;
`ifdef JPEG_RESTART_MARKER_EN
                    rst_idx_d   = 3'd0;
                    mcu_cnt_d   = 16'd0;
`endif
                end
            end
            ST_HDR: begin
                // A done coincident with the start pulse belongs to no request of ours.
                if (hdr_done && !hdr_start_q) begin
                    state_d     = ST_ISSUE;
                    blk_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (blk_valid_q && blk_ready) begin
                    state_d     = ST_WAIT;
                    blk_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (blk_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                cnt_inc = 1'b1;
                if (cnt_last) begin
                    state_d     = ST_EOI;
                    eoi_start_d = 1'b1;
                end else begin
                    state_d     = ST_ISSUE;
                    blk_valid_d = 1'b1;
`ifdef JPEG_RESTART_MARKER_EN
                    if (cnt_mcu_wrap) begin
                        if (mcu_cnt_inc == 16'(RST_INTERVAL)) begin
                            mcu_cnt_d       = 16'd0;
                            state_d         = ST_RSTM;
                            blk_valid_d     = 1'b0;
                            rst_mrk_start_d = 1'b1;
                        end else begin
                            mcu_cnt_d = mcu_cnt_inc;
                        end
                    end
`endif
                end
            end
`ifdef JPEG_RESTART_MARKER_EN
            ST_RSTM: begin
                // After a restart marker the DC predictors start over.
                if (rst_mrk_done && !rst_mrk_start_q) begin
                    state_d     = ST_ISSUE;
                    blk_valid_d = 1'b1;
                    dc_clr_d    = 1'b1;
                    rst_idx_d   = rst_idx_q + 3'd1;
                end
            end
`endif
            ST_EOI: begin
                if (eoi_done && !eoi_start_q) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            ST_DONE: begin
                // Start is deliberately not looked at here.
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
`ifdef JPEG_RESTART_MARKER_EN
                mcu_cnt_d = 16'd0;
`endif
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                blk_valid_d = 1'b0;
                cnt_clr     = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops everything to idle immediately.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            hdr_start_q  <= 1'b0;
            dc_clr_q     <= 1'b0;
            eoi_start_q  <= 1'b0;
            blk_valid_q  <= 1'b0;
`ifdef JPEG_RESTART_MARKER_EN
            rst_mrk_start_q <= 1'b0;
            rst_idx_q       <= 3'd0;
            mcu_cnt_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            hdr_start_q  <= hdr_start_d;
            dc_clr_q     <= dc_clr_d;
            eoi_start_q  <= eoi_start_d;
            blk_valid_q  <= blk_valid_d;
`ifdef JPEG_RESTART_MARKER_EN
            rst_mrk_start_q <= rst_mrk_start_d;
            rst_idx_q       <= rst_idx_d;
            mcu_cnt_q       <= mcu_cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign hdr_start  = hdr_start_q;
    assign dc_clr     = dc_clr_q;
    assign eoi_start  = eoi_start_q;
    assign blk_valid  = blk_valid_q;
    assign blk_last   = cnt_last;

`ifdef JPEG_RESTART_MARKER_EN
    assign rst_mrk_start = rst_mrk_start_q;
    assign rst_mrk_idx   = rst_idx_q;
`else
    assign rst_mrk_start = 1'b0;
    assign rst_mrk_idx   = 3'd0;
`endif

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Bench for jpeg_frame_ctrl on a 16x16 image (2x2 MCUs, 3 components, 12 blocks).
// Define JPEG_RESTART_MARKER_EN for both bench and RTL to exercise restart markers.
module tb_jpeg_frame_ctrl;

    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
    localparam int N_COMP = 3;
    localparam int RST_INTERVAL = 1;
    localparam int NBLK = 12;
`ifdef JPEG_RESTART_MARKER_EN
    localparam int DC_PER_FRAME = 4;
`else
    localparam int DC_PER_FRAME = 1;
`endif

    logic       sys_clk = 1'b0;
    logic       rst_n, start;
    logic       busy, frame_done, hdr_start, hdr_done;
    logic       blk_valid, blk_ready, blk_last, blk_done;
    logic [0:0] blk_x, blk_y;
    logic [1:0] blk_comp;
    logic       dc_clr, eoi_start, eoi_done, rst_mrk_start;
    logic [2:0] rst_mrk_idx;
`ifdef JPEG_RESTART_MARKER_EN
    logic       rst_mrk_done;
`endif

    always #5 sys_clk = ~sys_clk;

    jpeg_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .N_COMP(N_COMP), .RST_INTERVAL(RST_INTERVAL)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .busy(busy),
        .frame_done(frame_done), .hdr_start(hdr_start), .hdr_done(hdr_done),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_x(blk_x), .blk_y(blk_y),
        .blk_comp(blk_comp), .blk_last(blk_last), .blk_done(blk_done),
        .dc_clr(dc_clr), .eoi_start(eoi_start), .eoi_done(eoi_done),
        .rst_mrk_start(rst_mrk_start), .rst_mrk_idx(rst_mrk_idx)
`ifdef JPEG_RESTART_MARKER_EN
        , .rst_mrk_done(rst_mrk_done)
`endif
    );

    typedef struct packed {
        logic [0:0] x;
        logic [0:0] y;
        logic [1:0] comp;
        logic       last;
    } blk_t;

    blk_t vecs [0:NBLK-1];

    // Monitor logs (written only by the monitor process).
    blk_t hs_log [0:255];
    int   mrk_idx_log [0:63];
    int   mrk_at_hs [0:63];
    int   hs_count = 0, n_hdr = 0, n_dc = 0, n_eoi = 0, n_fd = 0, n_mrk = 0;

    // Responder controls (written only by the main process).
    int   ready_lat = 1;
    int   inj_hdr_at = -1;

    int   n_checks = 0, n_pass = 0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [14:0] outs();
        return {busy, frame_done, hdr_start, blk_valid, blk_x, blk_y, blk_comp, blk_last,
                dc_clr, eoi_start, rst_mrk_start, rst_mrk_idx};
    endfunction

    // Monitor: at the falling edge, log handshakes and count pulse-cycles.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (blk_valid && blk_ready) begin
                if (hs_count < 256) hs_log[hs_count] = '{x: blk_x, y: blk_y, comp: blk_comp, last: blk_last};
                $display("hs %0d: x=%0d y=%0d comp=%0d last=%0d", hs_count, blk_x, blk_y, blk_comp, blk_last);
                hs_count++;
            end
            if (hdr_start) n_hdr++;
            if (dc_clr) n_dc++;
            if (eoi_start) n_eoi++;
            if (frame_done) n_fd++;
            if (rst_mrk_start) begin
                if (n_mrk < 64) begin
                    mrk_idx_log[n_mrk] = int'(rst_mrk_idx);
                    mrk_at_hs[n_mrk]   = hs_count;
                end
                n_mrk++;
            end
        end
    end

    // Responders: each done answers one cycle after its start; ready follows ready_lat.
    initial begin
        automatic logic hdr_pend = 0, done_pend = 0, eoi_pend = 0, mrk_pend = 0, pv = 0, hs;
        automatic int age = 0;
        hdr_done = 0; blk_ready = 0; blk_done = 0; eoi_done = 0;
`ifdef JPEG_RESTART_MARKER_EN
        rst_mrk_done = 0;
`endif
        forever begin
            @(posedge sys_clk);
            #1;
            hs = pv && blk_ready;
            if (!rst_n) begin
                hdr_pend = 0; done_pend = 0; eoi_pend = 0; mrk_pend = 0; pv = 0; age = 0;
                hdr_done = 0; blk_ready = 0; blk_done = 0; eoi_done = 0;
`ifdef JPEG_RESTART_MARKER_EN
                rst_mrk_done = 0;
`endif
            end else begin
                hdr_done  = hdr_pend || (blk_valid && hs_count == inj_hdr_at);
                hdr_pend  = hdr_start;
                blk_done  = done_pend;
                done_pend = hs;
                eoi_done  = eoi_pend;
                eoi_pend  = eoi_start;
`ifdef JPEG_RESTART_MARKER_EN
                rst_mrk_done = mrk_pend;
`endif
                mrk_pend  = rst_mrk_start;
                age       = blk_valid ? age + 1 : 0;
                blk_ready = blk_valid && (age > ready_lat);
                pv        = blk_valid;
            end
        end
    end

    task automatic wait_hs(input int target, input string tag);
        for (int k = 0; k < 500 && hs_count < target; k++) tick();
        if (hs_count < target) chk({tag, "_hs_timeout"}, hs_count, target);
    endtask

    task automatic wait_fd(input string tag);
        for (int k = 0; k < 3000 && frame_done !== 1'b1; k++) tick();
        if (frame_done !== 1'b1) chk({tag, "_frame_done_timeout"}, 0, 1);
    endtask

    task automatic check_frame(input int b_hs, input int b_dc, input int b_mrk, input string tag);
        chk({tag, "_nblk"}, hs_count - b_hs, NBLK);
        for (int i = 0; i < NBLK; i++)
            if (b_hs + i < 256) chk($sformatf("%s_blk%0d", tag, i), hs_log[b_hs + i], vecs[i]);
        chk({tag, "_dc_clr_cnt"}, n_dc - b_dc, DC_PER_FRAME);
`ifdef JPEG_RESTART_MARKER_EN
        chk({tag, "_nmrk"}, n_mrk - b_mrk, 3);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("%s_mrk%0d_idx", tag, m), mrk_idx_log[b_mrk + m], m);
            chk($sformatf("%s_mrk%0d_pos", tag, m), mrk_at_hs[b_mrk + m] - b_hs, 3 * (m + 1));
        end
`else
        chk({tag, "_nmrk"}, n_mrk - b_mrk, 0);
`endif
    endtask

    initial begin
        int b_hs, b_dc, b_mrk, b_hdr, b_eoi, b_fd;
        rst_n = 1'b0;
        start = 1'b0;
        // Expected handshake order for a 2x2-MCU, 3-component frame: {x, y, comp, last}.
        vecs[0]  = '{x: 0, y: 0, comp: 0, last: 0};
        vecs[1]  = '{x: 0, y: 0, comp: 1, last: 0};
        vecs[2]  = '{x: 0, y: 0, comp: 2, last: 0};
        vecs[3]  = '{x: 1, y: 0, comp: 0, last: 0};
        vecs[4]  = '{x: 1, y: 0, comp: 1, last: 0};
        vecs[5]  = '{x: 1, y: 0, comp: 2, last: 0};
        vecs[6]  = '{x: 0, y: 1, comp: 0, last: 0};
        vecs[7]  = '{x: 0, y: 1, comp: 1, last: 0};
        vecs[8]  = '{x: 0, y: 1, comp: 2, last: 0};
        vecs[9]  = '{x: 1, y: 1, comp: 0, last: 0};
        vecs[10] = '{x: 1, y: 1, comp: 1, last: 0};
        vecs[11] = '{x: 1, y: 1, comp: 2, last: 1};

        repeat (3) tick();
        chk("reset_outputs", outs(), 0);
        #2 rst_n = 1'b1;
        tick(); tick();
        chk("idle_outputs", outs(), 0);

        // Test 1: full frame with one-cycle responders.
        b_hs = hs_count; b_dc = n_dc; b_mrk = n_mrk; b_hdr = n_hdr; b_eoi = n_eoi; b_fd = n_fd;
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_hdr_start", hdr_start, 1);
        chk("t1_dc_clr_entry", dc_clr, 1);
        chk("t1_busy_rise", busy, 1);
        tick();
        chk("t1_hdr_start_one_cycle", hdr_start, 0);
        wait_fd("t1");
        chk("t1_busy_low_at_done", busy, 0);
        tick();
        chk("t1_frame_done_one_cycle", frame_done, 0);
        chk("t1_busy_after", busy, 0);
        check_frame(b_hs, b_dc, b_mrk, "t1");
        chk("t1_hdr_cnt", n_hdr - b_hdr, 1);
        chk("t1_eoi_cnt", n_eoi - b_eoi, 1);
        chk("t1_fd_cnt", n_fd - b_fd, 1);

        // Test 2: ready held low 5 cycles on the second request.
        ready_lat = 5;
        b_hs = hs_count; b_dc = n_dc; b_mrk = n_mrk;
        start = 1'b1; tick(); start = 1'b0;
        wait_hs(b_hs + 1, "t2");
        for (int k = 0; k < 50 && !blk_valid; k++) tick();
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t2_valid_hold%0d", j), blk_valid, 1);
            chk($sformatf("t2_fields_hold%0d", j), {blk_x, blk_y, blk_comp, blk_last}, vecs[1]);
            tick();
        end
        chk("t2_no_hs_while_ready_low", hs_count - b_hs, 1);
        wait_fd("t2");
        tick();
        check_frame(b_hs, b_dc, b_mrk, "t2");
        ready_lat = 1;

        // Test 3: start during WAIT, spurious hdr_done in ISSUE, start during DONE.
        b_hs = hs_count; b_dc = n_dc; b_mrk = n_mrk; b_hdr = n_hdr;
        inj_hdr_at = b_hs + 3;
        start = 1'b1; tick(); start = 1'b0;
        wait_hs(b_hs + 2, "t3");
        start = 1'b1; tick(); start = 1'b0;
        wait_fd("t3");
        inj_hdr_at = -1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        check_frame(b_hs, b_dc, b_mrk, "t3");
        chk("t3_hdr_cnt", n_hdr - b_hdr, 1);
        chk("t3_busy_after", busy, 0);
        chk("t3_no_request_after", blk_valid, 0);

        // Test 4: asynchronous reset while waiting on block 5, then a clean restart.
        b_hs = hs_count;
        start = 1'b1; tick(); start = 1'b0;
        wait_hs(b_hs + 5, "t4");
        chk("t4_busy_before_rst", busy, 1);
        chk("t4_pos_before_rst", {blk_x, blk_y, blk_comp}, 4'b1001);
        #2 rst_n = 1'b0;
        #1 chk("t4_outputs_at_rst", outs(), 0);
        repeat (3) tick();
        chk("t4_outputs_in_rst", outs(), 0);
        b_hdr = n_hdr; b_eoi = n_eoi;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t4_no_pulses_after_rst", (n_hdr - b_hdr) + (n_eoi - b_eoi), 0);
        chk("t4_outputs_after_rst", outs(), 0);
        b_hs = hs_count; b_dc = n_dc; b_mrk = n_mrk;
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_hdr_start_restart", hdr_start, 1);
        wait_fd("t4");

        // Test 6: start one cycle after frame_done.
        tick();
        chk("t6_frame_done_low", frame_done, 0);
        check_frame(b_hs, b_dc, b_mrk, "t4");
        b_hs = hs_count; b_dc = n_dc; b_mrk = n_mrk;
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_hdr_start", hdr_start, 1);
        chk("t6_counters_zero", {blk_x, blk_y, blk_comp}, 0);
        wait_fd("t6");
        tick();
        check_frame(b_hs, b_dc, b_mrk, "t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jpeg_frame_ctrl.md
Name: jpeg_frame_ctrl

Overview:
Frame-level sequencer for the JPEG encoder. On a one-cycle `start` pulse it runs three phases:
- header emission;
- MCU/component block iteration through the block encoder (DCT/quant/Huffman), over a valid/ready + done handshake;
- EOI emission.
It sits between the top-level `start` input and the encoder datapath, and replaces ad-hoc start wiring in top.

Parameters:
- IMG_W, 640, image width in pixels, multiple of 8
- IMG_H, 480, image height in pixels, multiple of 8
- N_COMP, 3, components per MCU (4:4:4; order Y=0, Cb=1, Cr=2)
- RST_INTERVAL, 4, MCUs between restart markers (used only with the optional feature; must be ≥1)

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; ignored while busy
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse after EOI completes
- hdr_start  out  1  one-cycle pulse: header writer begins SOI..SOS
- hdr_done  in  1  header writer finished (pulse)
- blk_valid  out  1  block request valid
- blk_ready  in  1  encoder accepts request
- blk_x  out  $clog2(IMG_W/8)  MCU column
- blk_y  out  $clog2(IMG_H/8)  MCU row
- blk_comp  out  2  component index
- blk_last  out  1  request is the final block of the frame
- blk_done  in  1  encoder finished the accepted block (pulse)
- dc_clr  out  1  one-cycle pulse clearing the DC predictors
- eoi_start  out  1  one-cycle pulse: emit EOI
- eoi_done  in  1  EOI emitted (pulse)
- rst_mrk_start  out  1  restart marker request pulse (optional feature)
- rst_mrk_idx  out  3  RSTn index, 0..7

Behaviour:
Reset values: every output is 0, and the FSM is in IDLE. Reset is asynchronous and may occur mid-frame. After reset:
- no further pulses are issued;
- the counters return to 0.

FSM transitions:
- IDLE: start=1 → HDR. On entry to HDR, hdr_start and dc_clr pulse in the same cycle, and busy rises one cycle after start.
- HDR: wait for hdr_done → ISSUE. A hdr_done in the same cycle as hdr_start entry is not accepted; done is sampled only while in HDR.
- ISSUE: blk_valid=1, and blk_x/y/comp/last are held stable until blk_valid && blk_ready.
  - A handshake → WAIT.
  - Zero extra latency: valid asserts on the first ISSUE cycle.
- WAIT: blk_done → NEXT. A blk_done arriving in the same cycle as the handshake is not counted.
- NEXT (one cycle): advance the counters.
  - Order: comp fastest, then x, then y.
  - comp wraps N_COMP-1→0 and increments x; x wraps MCU_X-1→0 and increments y.
  - If the block just completed had blk_last=1 → EOI; otherwise → ISSUE.
- EOI: eoi_start pulses on entry; wait for eoi_done → DONE.
- DONE (one cycle): frame_done=1, busy drops in this cycle, counters are cleared → IDLE.

Rules:
- blk_last = (x==MCU_X-1) && (y==MCU_Y-1) && (comp==N_COMP-1).
- Total blocks per frame = MCU_X·MCU_Y·N_COMP, where MCU_X=IMG_W/8 and MCU_Y=IMG_H/8.
- start while busy: ignored, not queued.
- start in the same cycle as DONE: ignored.
- Done inputs outside their waiting state are ignored.
- There is no timeout; the block waits indefinitely.

Optional Feature:
Macro: JPEG_RESTART_MARKER_EN.

When defined:
- A 16-bit MCU counter increments in NEXT when comp wraps.
- If the count reaches a multiple of RST_INTERVAL and the MCU is not the last, NEXT → RSTM.
- RSTM: rst_mrk_start pulses on entry, with rst_mrk_idx set to the current index. On rst_mrk_done (an extra input port, 1 bit, present only under the macro), dc_clr pulses and the FSM → ISSUE.
- rst_mrk_idx increments mod 8 after each marker and resets to 0 at HDR.

When undefined:
- There is no RSTM state and no rst_mrk_done port.
- rst_mrk_start and rst_mrk_idx are tied to 0.

Decomposition:
Package jpeg_ctrl_pkg holds:
- state enum (IDLE, HDR, ISSUE, WAIT, NEXT, RSTM, EOI, DONE);
- component enum (COMP_Y, COMP_CB, COMP_CR);
- marker constants SOI=16'hFFD8, EOI=16'hFFD9, RST0=16'hFFD0.

One sub-module, jpeg_mcu_counter, implements the nested comp/x/y counter. Its interface: inc, clr, x, y, comp, last, mcu_wrap.

Test Plan:
1. IMG_W=16, IMG_H=16, with ready and done responding after 1 cycle → exactly 12 handshakes in order (0,0,Y),(0,0,Cb),(0,0,Cr),(1,0,Y)…(1,1,Cr); blk_last only on the 12th; one eoi_start; frame_done pulse; busy low afterwards.
2. blk_ready held low for 5 cycles in ISSUE → blk_x/y/comp stay constant and blk_valid stays high until the handshake.
3. start re-pulsed during WAIT, plus a spurious hdr_done in ISSUE → no effect; block count is still 12.
4. rst_n asserted in WAIT at block 5 → all outputs 0 immediately; a new start restarts from (0,0,Y) with hdr_start.
5. JPEG_RESTART_MARKER_EN, RST_INTERVAL=1, 16×16 frame → 3 rst_mrk_start pulses with idx 0,1,2; none after the last MCU; dc_clr pulses 4 times in total.
6. Back-to-back frames with start asserted 1 cycle after frame_done → second frame is accepted; counters are at 0.
